// File: rtl/video_pio_pkg.sv
// Shared constants for the video-path status PIO: register addresses and
// edge-capture encodings, plus the edge-match helper used by the capture logic.
package video_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum int unsigned {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } edge_type_e;

  // True when a transition to new_val is one this edge type captures.
  function automatic logic edge_match(input int unsigned edge_type, input logic new_val);
    case (edge_type)
      EDGE_RISING:  return new_val;
      EDGE_FALLING: return ~new_val;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One status line: two-flop synchroniser, consecutive-cycle debounce counter
// and accepted (stable) value, with a one-cycle update strobe at acceptance.
module pio_debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic stable_o,
  output logic update_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES == 0) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          update;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= in_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // update_o is combinational: it marks the edge at which stable_o flips.
  assign stable_o = stable_q;
  assign update_o = update;

endmodule

// File: rtl/video_router_status_pio_in.sv
// Avalon-MM PIO-in for edge-detection video status lines: debounced DATA,
// IRQMASK, W1C EDGECAP and a level interrupt to the Nios II.
module video_router_status_pio_in
  import video_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter int unsigned EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable, update, capset;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rd_q, rd_d;
  logic             wr_en, rd_en;
  logic             unused_wd;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[g]),
      .stable_o(stable[g]),
      .update_o(update[g])
    );
  end

  assign wr_en     = chipselect && !write_n;
  assign rd_en     = chipselect && !read_n;
  assign unused_wd = ^writedata;

  always_comb begin
    capset = '0;
    // The new accepted value is the complement of the current stable bit.
    for (int unsigned i = 0; i < WIDTH; i++)
      capset[i] = update[i] && edge_match(EDGE_TYPE, ~stable[i]);
  end

  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
    if (wr_en && address == ADDR_EDGECAP) cap_d = cap_q & ~writedata[WIDTH-1:0];
    // Applied after the clear so a coincident capture wins.
    cap_d = cap_d | capset;
  end

  always_comb begin
    rd_d = '0;
    if (rd_en) begin
      case (address)
        ADDR_DATA:    rd_d = 32'(stable);
        ADDR_IRQMASK: rd_d = 32'(mask_q);
        ADDR_EDGECAP: rd_d = 32'(cap_q);
        default:      rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      cap_q  <= '0;
      rd_q   <= '0;
    end else begin
      mask_q <= mask_d;
      cap_q  <= cap_d;
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = |(cap_q & mask_q);

endmodule
